// File: rtl/flow_key_hasher.sv
`default_nettype none
// ============================================================================
// Module   : flow_key_hasher
// Brief    : Captures parsed flow keys, queues them, computes CRC-16-CCITT and
//            CRC-16-IBM table indices and presents them to the flow table.
// Revision : 1.0
// ============================================================================
module flow_key_hasher #(
    parameter int KEY_WIDTH        = 264,
    parameter int FIFO_DEPTH_BITS  = 2,
    parameter int TABLE_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [KEY_WIDTH-1:0]        header_bus,
    input  logic                        headers_valid,
    output logic                        lookup_req,
    output logic [KEY_WIDTH-1:0]        lookup_key,
    output logic [TABLE_ADDR_WIDTH-1:0] lookup_hash0,
    output logic [TABLE_ADDR_WIDTH-1:0] lookup_hash1,
    input  logic                        lookup_ack,
    output logic                        key_fifo_full,
    output logic [31:0]                 drop_count
);

    localparam int                     c_DEPTH     = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] c_DEPTH_CNT = (FIFO_DEPTH_BITS+1)'(c_DEPTH);
    localparam int                     c_NUM_WORDS = (KEY_WIDTH + 31) / 32;
    localparam int                     c_STREAM_W  = c_NUM_WORDS * 32;
    localparam int                     c_PAD_W     = c_STREAM_W - KEY_WIDTH;
    localparam logic [3:0]             c_LAST_WORD = 4'(c_NUM_WORDS - 1);
    localparam logic [15:0]            c_POLY0     = 16'h1021;
    localparam logic [15:0]            c_POLY1     = 16'h8005;
    localparam logic [15:0]            c_CRC_INIT  = 16'hFFFF;
    localparam logic [31:0]            c_DROP_MAX  = 32'hFFFF_FFFF;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HASH = 2'd1;
    localparam logic [1:0] c_ST_REQ  = 2'd2;

    // Non-reflected CRC-16 over one 32-bit word, MSB first, no final XOR.
    function automatic logic [15:0] f_crc_fold(
        input logic [15:0] crc_in,
        input logic [31:0] word,
        input logic [15:0] poly
    );
        logic [15:0] crc;
        logic        fb;
        crc = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb  = crc[15] ^ word[i];
            crc = {crc[14:0], 1'b0};
            if (fb) begin
                crc = crc ^ poly;
            end
        end
        return crc;
    endfunction

    logic                         r_hv_prev;
    logic                         w_capture;
    logic                         w_fifo_full;
    logic                         w_push;
    logic                         w_drop;
    logic                         w_pop;

    logic [KEY_WIDTH-1:0]         r_mem [c_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]   r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0]   r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]     r_count;
    logic [FIFO_DEPTH_BITS:0]     w_count_nxt;
    logic                         r_key_fifo_full;
    logic [31:0]                  r_drop_count;

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nxt;
    logic [KEY_WIDTH-1:0]         r_key;
    logic [15:0]                  r_crc0;
    logic [15:0]                  r_crc1;
    logic [3:0]                   r_word_idx;
    logic [c_STREAM_W-1:0]        w_stream;
    logic [31:0]                  w_word;
    logic [15:0]                  w_crc0_nxt;
    logic [15:0]                  w_crc1_nxt;
    logic                         w_last_word;

    logic [KEY_WIDTH-1:0]         r_lookup_key;
    logic [TABLE_ADDR_WIDTH-1:0]  r_lookup_hash0;
    logic [TABLE_ADDR_WIDTH-1:0]  r_lookup_hash1;

    // Capture and FIFO control; a push while full is dropped even if a pop frees a slot.
    assign w_capture   = headers_valid & ~r_hv_prev;
    assign w_fifo_full = (r_count == c_DEPTH_CNT);
    assign w_push      = w_capture & ~w_fifo_full;
    assign w_drop      = w_capture & w_fifo_full;
    assign w_pop       = (r_state == c_ST_IDLE) && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hv_prev       <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_key_fifo_full <= 1'b0;
            r_drop_count    <= '0;
        end else begin
            r_hv_prev       <= headers_valid;
            r_count         <= w_count_nxt;
            r_key_fifo_full <= (w_count_nxt == c_DEPTH_CNT);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop && (r_drop_count != c_DROP_MAX)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= header_bus;
        end
    end

    // Key stream is MSB-first words, the last one zero-padded at the bottom.
    assign w_stream = c_STREAM_W'(r_key) << c_PAD_W;

    always_comb begin
        w_word = '0;
        for (int k = 0; k < c_NUM_WORDS; k++) begin
            if (r_word_idx == 4'(k)) begin
                w_word = w_stream[c_STREAM_W-1-32*k -: 32];
            end
        end
    end

    assign w_crc0_nxt  = f_crc_fold(r_crc0, w_word, c_POLY0);
    assign w_crc1_nxt  = f_crc_fold(r_crc1, w_word, c_POLY1);
    assign w_last_word = (r_word_idx == c_LAST_WORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_pop)       w_state_nxt = c_ST_HASH;
            c_ST_HASH: if (w_last_word) w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (lookup_ack)  w_state_nxt = c_ST_IDLE;
            default:                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key          <= '0;
            r_crc0         <= '0;
            r_crc1         <= '0;
            r_word_idx     <= '0;
            r_lookup_key   <= '0;
            r_lookup_hash0 <= '0;
            r_lookup_hash1 <= '0;
        end else begin
            if (w_pop) begin
                r_key      <= r_mem[r_rd_ptr];
                r_crc0     <= c_CRC_INIT;
                r_crc1     <= c_CRC_INIT;
                r_word_idx <= '0;
            end else if (r_state == c_ST_HASH) begin
                r_crc0     <= w_crc0_nxt;
                r_crc1     <= w_crc1_nxt;
                r_word_idx <= r_word_idx + 4'd1;
                if (w_last_word) begin
                    r_lookup_key   <= r_key;
                    r_lookup_hash0 <= w_crc0_nxt[TABLE_ADDR_WIDTH-1:0];
                    r_lookup_hash1 <= w_crc1_nxt[TABLE_ADDR_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        lookup_req    = (r_state == c_ST_REQ);
        lookup_key    = r_lookup_key;
        lookup_hash0  = r_lookup_hash0;
        lookup_hash1  = r_lookup_hash1;
        key_fifo_full = r_key_fifo_full;
        drop_count    = r_drop_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_flow_key_hasher.sv
`default_nettype none
// ============================================================================
// Module   : tb_flow_key_hasher
// Brief    : Scoreboard bench for flow_key_hasher with a bit-serial CRC model.
// Revision : 1.0
// ============================================================================
module tb_flow_key_hasher;

    localparam int KW = 264;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [KW-1:0] header_bus;
    logic          headers_valid;
    logic          lookup_req;
    logic [KW-1:0] lookup_key;
    logic [AW-1:0] lookup_hash0;
    logic [AW-1:0] lookup_hash1;
    logic          lookup_ack;
    logic          key_fifo_full;
    logic [31:0]   drop_count;

    flow_key_hasher #(
        .KEY_WIDTH        (KW),
        .FIFO_DEPTH_BITS  (2),
        .TABLE_ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .header_bus    (header_bus),
        .headers_valid (headers_valid),
        .lookup_req    (lookup_req),
        .lookup_key    (lookup_key),
        .lookup_hash0  (lookup_hash0),
        .lookup_hash1  (lookup_hash1),
        .lookup_ack    (lookup_ack),
        .key_fifo_full (key_fifo_full),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0] key;
        logic [AW-1:0] h0;
        logic [AW-1:0] h1;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_req = 0;
    logic prev_req = 1'b0;

    task automatic check_val(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference CRC: bit-serial over the key followed by 24 zero bits.
    function automatic logic [15:0] crc_model(input logic [KW-1:0] key, input logic [15:0] poly);
        logic [KW+23:0] s;
        logic [15:0]    crc;
        logic           fb;
        s   = {key, 24'h0};
        crc = 16'hFFFF;
        for (int i = KW + 23; i >= 0; i--) begin
            fb  = crc[15] ^ s[i];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ poly;
        end
        return crc;
    endfunction

    function automatic logic [KW-1:0] mk_key(input logic [15:0] port);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < 9; i++) k = {k[KW-33:0], 32'($urandom)};
        k[15:0] = port;
        return k;
    endfunction

    task automatic push_exp(input logic [KW-1:0] key);
        exp_t     e;
        logic [15:0] c0;
        logic [15:0] c1;
        c0    = crc_model(key, 16'h1021);
        c1    = crc_model(key, 16'h8005);
        e.key = key;
        e.h0  = c0[AW-1:0];
        e.h1  = c1[AW-1:0];
        exp_q.push_back(e);
    endtask

    // Scoreboard: every new request is compared against the oldest expected key.
    always @(negedge clk) begin
        if (lookup_req && !prev_req) begin
            n_req++;
            check_val("req_expected", KW'(exp_q.size() != 0), KW'(1));
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("lookup_key", lookup_key, e.key);
                check_val("lookup_hash0", KW'(lookup_hash0), KW'(e.h0));
                check_val("lookup_hash1", KW'(lookup_hash1), KW'(e.h1));
            end
        end
        prev_req = lookup_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_packet(input logic [KW-1:0] key, input bit drop, input int gap);
        header_bus    = key;
        headers_valid = 1'b1;
        if (!drop) push_exp(key);
        step();
        headers_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!lookup_req && n < budget) begin
            step();
            n++;
        end
        check_val("req_timeout", KW'(lookup_req), KW'(1));
    endtask

    task automatic wait_and_ack();
        wait_req(60);
        lookup_ack = 1'b1;
        step();
        lookup_ack = 1'b0;
    endtask

    task automatic wait_no_req(input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            step();
            if (lookup_req) seen = 1'b1;
        end
        check_val("no_req", KW'(seen), KW'(0));
    endtask

    // Ack at edge A, capture at A+1 so the capture coincides with the engine pop.
    task automatic ack_with_capture(input logic [KW-1:0] key, input bit drop);
        wait_req(60);
        lookup_ack = 1'b1;
        step();
        lookup_ack = 1'b0;
        header_bus    = key;
        headers_valid = 1'b1;
        if (!drop) push_exp(key);
        step();
        headers_valid = 1'b0;
        step();
    endtask

    task automatic latency_run(input logic [KW-1:0] key, input bit noisy_ack);
        if (noisy_ack) begin
            lookup_ack = 1'b1;
            step();
            lookup_ack = 1'b0;
            step();
        end
        header_bus    = key;
        headers_valid = 1'b1;
        push_exp(key);
        step();
        check_val("lat_e0_req", KW'(lookup_req), KW'(0));
        for (int i = 1; i <= 9; i++) begin
            lookup_ack = noisy_ack & i[0];
            step();
            if (i == 3) headers_valid = 1'b0;
        end
        lookup_ack = 1'b0;
        check_val("lat_e9_req", KW'(lookup_req), KW'(0));
        step();
        check_val("lat_e10_req", KW'(lookup_req), KW'(1));
        repeat (4) step();
        check_val("lat_e14_req", KW'(lookup_req), KW'(1));
        lookup_ack = 1'b1;
        step();
        lookup_ack = 1'b0;
        check_val("lat_e15_req", KW'(lookup_req), KW'(0));
        check_val("key_hold", lookup_key, key);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KW-1:0] k;
        int            base;

        reset         = 1'b1;
        headers_valid = 1'b0;
        header_bus    = '0;
        lookup_ack    = 1'b0;
        pulse_reset();

        check_val("rst_req", KW'(lookup_req), KW'(0));
        check_val("rst_key", lookup_key, '0);
        check_val("rst_hash0", KW'(lookup_hash0), '0);
        check_val("rst_hash1", KW'(lookup_hash1), '0);
        check_val("rst_full", KW'(key_fifo_full), '0);
        check_val("rst_drops", KW'(drop_count), '0);

        // Single packet into an idle engine.
        k = '0;
        k[151:136] = 16'h0800;
        latency_run(k, 1'b0);

        // Long headers_valid level yields one capture per rising edge.
        base = n_req;
        k = mk_key(16'h00A1);
        header_bus    = k;
        headers_valid = 1'b1;
        push_exp(k);
        repeat (20) step();
        headers_valid = 1'b0;
        step();
        k = mk_key(16'h00B2);
        header_bus    = k;
        headers_valid = 1'b1;
        push_exp(k);
        repeat (3) step();
        headers_valid = 1'b0;
        wait_and_ack();
        wait_and_ack();
        wait_no_req(30);
        check_val("level_req_count", KW'(n_req - base), KW'(2));
        check_val("level_q_empty", KW'(exp_q.size()), '0);

        // Ack held low: fill engine + FIFO, sixth packet dropped.
        for (int p = 1; p <= 6; p++) begin
            send_packet(mk_key(16'(p)), p == 6, 2);
            if (p == 5) check_val("fill_full", KW'(key_fifo_full), KW'(1));
        end
        check_val("fill_drops", KW'(drop_count), KW'(1));
        repeat (5) wait_and_ack();
        check_val("fill_q_empty", KW'(exp_q.size()), '0);
        check_val("fill_full_clear", KW'(key_fifo_full), '0);

        // Simultaneous push and pop, first with room, then while full.
        pulse_reset();
        for (int p = 1; p <= 4; p++) send_packet(mk_key(16'(16 + p)), 1'b0, 2);
        check_val("pp_pre_full", KW'(key_fifo_full), '0);
        ack_with_capture(mk_key(16'd21), 1'b0);
        check_val("pp_room_full", KW'(key_fifo_full), '0);
        check_val("pp_room_drops", KW'(drop_count), '0);
        send_packet(mk_key(16'd22), 1'b0, 2);
        check_val("pp_now_full", KW'(key_fifo_full), KW'(1));
        ack_with_capture(mk_key(16'd23), 1'b1);
        check_val("pp_full_drops", KW'(drop_count), KW'(1));
        check_val("pp_full_after", KW'(key_fifo_full), '0);
        repeat (4) wait_and_ack();
        check_val("pp_q_empty", KW'(exp_q.size()), '0);

        // Reset during HASH cycle 5 with two keys queued.
        send_packet(mk_key(16'd31), 1'b0, 1);
        send_packet(mk_key(16'd32), 1'b0, 1);
        send_packet(mk_key(16'd33), 1'b0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check_val("mid_rst_req", KW'(lookup_req), '0);
        check_val("mid_rst_key", lookup_key, '0);
        check_val("mid_rst_hash0", KW'(lookup_hash0), '0);
        check_val("mid_rst_hash1", KW'(lookup_hash1), '0);
        check_val("mid_rst_full", KW'(key_fifo_full), '0);
        check_val("mid_rst_drops", KW'(drop_count), '0);
        wait_no_req(20);
        latency_run(mk_key(16'd34), 1'b0);

        // Stray acks while IDLE/HASH are ignored.
        latency_run(mk_key(16'd41), 1'b1);

        // Saturating drop counter.
        force dut.r_drop_count = 32'hFFFF_FFFE;
        #2;
        release dut.r_drop_count;
        for (int p = 1; p <= 7; p++) begin
            send_packet(mk_key(16'(48 + p)), p >= 6, 2);
            if (p >= 6) check_val("sat_drops", KW'(drop_count), KW'(32'hFFFF_FFFF));
        end
        repeat (5) wait_and_ack();
        check_val("sat_q_empty", KW'(exp_q.size()), '0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
